// File: rtl/hilo_pkg.sv
// hilo_pkg: shared encodings for the HI/LO multiply/divide unit.
// Holds HiLoOp codes, FSM state type and the divide-by-zero LO value.
package hilo_pkg;

  localparam int ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic logic is_signed_op(
    input logic [2:0] op
  );
    return (op == OP_MULT) || (op == OP_MADD) ||
           (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter.sv
// muldiv_iter_core: radix-2 shift-add multiply / restoring divide.
// Ports: Clk, Rst (sync, low), load_i/div_i/sgn_i/a_i/b_i latch an op,
// step_i runs one iteration, last_o flags the 32nd, res_o signed result.
module muldiv_iter_core
  import hilo_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load_i,
  input  logic        div_i,
  input  logic        sgn_i,
  input  logic        step_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        last_o,
  output logic [63:0] res_o
);

  logic [64:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum;
  logic [64:0] sh;
  logic [32:0] trial;
  logic [31:0] quo, rem;

  assign a_neg = sgn_i & a_i[31];
  assign b_neg = sgn_i & b_i[31];
  assign a_mag = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag = b_neg ? (~b_i + 32'd1) : b_i;

  // mul: add multiplicand into upper half when lsb set, then shift right
  assign sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  // div: shift remainder:quotient left, try subtracting the divisor
  assign sh    = {acc_q[63:0], 1'b0};
  assign trial = sh[64:32] - {1'b0, opnd_q};

  assign last_o = (cnt_q == 5'(ITER - 1));

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    if (load_i) begin
      cnt_d  = 5'd0;
      div_d  = div_i;
      neg_d  = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d   = div_i && (b_i == 32'd0);
      if (div_i && (b_i == 32'd0)) begin
        // raw dividend goes to HI unmodified
        acc_d  = {1'b0, a_i, DIV0_LO};
        opnd_d = 32'd0;
      end else if (div_i) begin
        acc_d  = {33'd0, a_mag};
        opnd_d = b_mag;
      end else begin
        acc_d  = {33'd0, b_mag};
        opnd_d = a_mag;
      end
    end else if (step_i) begin
      cnt_d = cnt_q + 5'd1;
      if (div_q) begin
        if (!trial[32])
          acc_d = {trial, sh[31:1], 1'b1};
        else
          acc_d = sh;
      end else begin
        if (acc_q[0])
          acc_d = {1'b0, sum, acc_q[31:1]};
        else
          acc_d = {1'b0, acc_q[64:1]};
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
    end
  end

  assign quo = acc_q[31:0];
  assign rem = acc_q[63:32];

  // sign fix-up: quotient truncates to zero, remainder follows dividend
  always_comb begin
    if (dz_q)
      res_o = acc_q[63:0];
    else if (div_q)
      res_o = {rneg_q ? (~rem + 32'd1) : rem,
               neg_q  ? (~quo + 32'd1) : quo};
    else
      res_o = neg_q ? (~acc_q[63:0] + 64'd1) : acc_q[63:0];
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO owner with iterative MULT/MADD/MSUB/DIV.
// Ports: Clk, Rst (sync, low), Start/HiLoOp/A/B, HiLoEn/HiLoWrite,
// HiLoRead {HI,LO}, Busy while iterating, Done pulse at FIN.
module hilo_muldiv_unit
  import hilo_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  HiLoOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoEn,
  input  logic [63:0] HiLoWrite,
  output logic [63:0] HiLoRead,
  output logic        Busy,
  output logic        Done
);

  state_e      state_q, state_d;
  logic [63:0] hilo_q, hilo_d;
  logic [2:0]  op_q, op_d;
  logic        load, step, last;
  logic        is_div;
  logic [63:0] res;

  assign is_div = (HiLoOp == OP_DIV) || (HiLoOp == OP_DIVU);

  muldiv_iter_core u_core (
    .Clk    (Clk),
    .Rst    (Rst),
    .load_i (load),
    .div_i  (is_div),
    .sgn_i  (is_signed_op(HiLoOp)),
    .step_i (step),
    .a_i    (A),
    .b_i    (B),
    .last_o (last),
    .res_o  (res)
  );

  always_comb begin
    state_d = state_q;
    hilo_d  = hilo_q;
    op_d    = op_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // direct ALU write wins; a same-cycle Start is dropped
        if (HiLoEn) begin
          hilo_d = HiLoWrite;
        end else if (Start) begin
          if (HiLoOp == OP_MTHI) begin
            hilo_d[63:32] = A;
          end else if (HiLoOp == OP_MTLO) begin
            hilo_d[31:0] = A;
          end else begin
            load = 1'b1;
            op_d = HiLoOp;
            if (!is_div)
              state_d = ST_MUL;
            else if (B == 32'd0)
              state_d = ST_FIN;
            else
              state_d = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        step = 1'b1;
        if (last)
          state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (op_q == OP_MADD)
          hilo_d = hilo_q + res;
        else if (op_q == OP_MSUB)
          hilo_d = hilo_q - res;
        else
          hilo_d = res;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      hilo_q  <= '0;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      hilo_q  <= hilo_d;
      op_q    <= op_d;
    end
  end

  assign HiLoRead = hilo_q;
  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_FIN);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors for hilo_muldiv_unit.
// Expected values are hand-computed constants.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  HiLoOp;
  logic [31:0] A, B;
  logic        HiLoEn;
  logic [63:0] HiLoWrite;
  logic [63:0] HiLoRead;
  logic        Busy, Done;

  int n_run  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  hilo_muldiv_unit dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .HiLoOp    (HiLoOp),
    .A         (A),
    .B         (B),
    .HiLoEn    (HiLoEn),
    .HiLoWrite (HiLoWrite),
    .HiLoRead  (HiLoRead),
    .Busy      (Busy),
    .Done      (Done)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Start     = 1'b0;
    HiLoOp    = 3'b000;
    A         = 32'd0;
    B         = 32'd0;
    HiLoEn    = 1'b0;
    HiLoWrite = 64'd0;
  endtask

  // called at a negedge with Busy=0; returns at a negedge after Busy falls
  task automatic run_op(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          exp_busy,
    input logic [63:0] exp_hilo,
    input bit          intf
  );
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    int guard = 0;
    Start  = 1'b1;
    HiLoOp = op;
    A      = a;
    B      = b;
    @(negedge Clk);
    idle_inputs();
    while (Busy && guard < 200) begin
      busy_n++;
      if (Done) begin
        done_n++;
        done_at = busy_n;
      end
      if (intf && busy_n == 5) begin
        Start     = 1'b1;
        HiLoOp    = 3'b111;
        A         = 32'h1234_5678;
        HiLoEn    = 1'b1;
        HiLoWrite = 64'hDEAD_BEEF_CAFE_F00D;
      end
      if (intf && busy_n == 6)
        idle_inputs();
      @(negedge Clk);
      guard++;
    end
    check({tag, "_timeout"}, 64'(guard >= 200), 64'd0);
    check({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
    check({tag, "_done_n"}, 64'(done_n), 64'd1);
    check({tag, "_done_at"}, 64'(done_at), 64'(exp_busy));
    check({tag, "_hilo"}, HiLoRead, exp_hilo);
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_hilo", HiLoRead, 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    Rst = 1'b1;
    @(negedge Clk);

    run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3,
           33, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);

    HiLoEn    = 1'b1;
    HiLoWrite = 64'h0000_0000_0000_0010;
    @(negedge Clk);
    idle_inputs();
    check("hiloen_val", HiLoRead, 64'h10);
    check("hiloen_busy", 64'(Busy), 64'd0);

    run_op("madd", 3'b010, 32'd4, 32'd5,
           33, 64'h24, 1'b0);
    run_op("msub", 3'b011, 32'd4, 32'd5,
           33, 64'h10, 1'b0);

    run_op("div_n7_2", 3'b100, 32'hFFFF_FFF9, 32'd2,
           33, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("div_7_n2", 3'b100, 32'd7, 32'hFFFF_FFFE,
           33, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_op("divu_by0", 3'b101, 32'd7, 32'd0,
           1, 64'h0000_0007_FFFF_FFFF, 1'b0);
    run_op("div_min_m1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
           33, 64'h0000_0000_8000_0000, 1'b0);
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'd16,
           33, 64'h0000_000F_0FFF_FFFF, 1'b0);

    run_op("multu_intf", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           33, 64'hFFFF_FFFE_0000_0001, 1'b1);

    Start     = 1'b1;
    HiLoOp    = 3'b000;
    A         = 32'd9;
    B         = 32'd9;
    HiLoEn    = 1'b1;
    HiLoWrite = 64'h0000_0001_0000_0002;
    @(negedge Clk);
    idle_inputs();
    check("race_hilo", HiLoRead, 64'h0000_0001_0000_0002);
    check("race_busy", 64'(Busy), 64'd0);
    repeat (3) @(negedge Clk);
    check("race_busy2", 64'(Busy), 64'd0);
    check("race_hilo2", HiLoRead, 64'h0000_0001_0000_0002);

    Start  = 1'b1;
    HiLoOp = 3'b111;
    A      = 32'h5555_AAAA;
    @(negedge Clk);
    idle_inputs();
    check("mtlo_val", HiLoRead, 64'h0000_0001_5555_AAAA);
    check("mtlo_busy", 64'(Busy), 64'd0);

    Start  = 1'b1;
    HiLoOp = 3'b100;
    A      = 32'd100;
    B      = 32'd7;
    @(negedge Clk);
    idle_inputs();
    repeat (10) @(negedge Clk);
    check("mid_busy", 64'(Busy), 64'd1);
    Rst = 1'b0;
    @(negedge Clk);
    check("midrst_hilo", HiLoRead, 64'd0);
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    Rst = 1'b1;
    Start  = 1'b1;
    HiLoOp = 3'b110;
    A      = 32'h0000_ABCD;
    @(negedge Clk);
    idle_inputs();
    check("mthi_val", HiLoRead, 64'h0000_ABCD_0000_0000);
    check("mthi_busy", 64'(Busy), 64'd0);

    run_op("b2b_mult", 3'b000, 32'd6, 32'hFFFF_FFF9,
           33, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
